// File: rtl/wb_commit_buffer_pkg.sv
// Shared types and constants for the writeback commit buffer.
// Entry layout width helper and the exception codes used by the CSR unit.
package wb_commit_buffer_pkg;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    // gr_we, dest, result, pc, badv, ex, ecode, badv_we, ertn
    function automatic int wb_entry_wd(int data_w, int ecode_w);
        return 1 + 5 + data_w + 32 + 32 + 1 + ecode_w + 1 + 1;
    endfunction

    localparam int WB_ENTRY_WD = wb_entry_wd(32, 6);

    typedef enum logic [1:0] {
        RET_NONE = 2'd0,
        RET_RF   = 2'd1,
        RET_EX   = 2'd2,
        RET_ERTN = 2'd3
    } retire_kind_e;

endpackage

// File: rtl/wb_commit_buffer_if.sv
// Handshake/bus bundle between memory stage, commit buffer, RF/CSR and decode.
// Forwarding signals exist only when WB_FWD_EN is defined.
interface wb_commit_buffer_if #(
    parameter int DATA_W  = 32,
    parameter int ECODE_W = 6
);
    logic                in_valid;
    logic                in_allowin;
    logic                in_gr_we;
    logic [4:0]          in_dest;
    logic [DATA_W-1:0]   in_result;
    logic [31:0]         in_pc;
    logic [31:0]         in_badv;
    logic                in_ex;
    logic [ECODE_W-1:0]  in_ecode;
    logic                in_badv_we;
    logic                in_ertn;
    logic                has_int;
    logic                retire_ready;
    logic                rf_we;
    logic [4:0]          rf_waddr;
    logic [DATA_W-1:0]   rf_wdata;
    logic                ex_req;
    logic [ECODE_W-1:0]  ex_ecode;
    logic [31:0]         ex_pc;
    logic [31:0]         ex_badv;
    logic                ex_badv_we;
    logic                ertn_req;
    logic                flush;
    logic                busy;
`ifdef WB_FWD_EN
    logic [4:0]          fwd_raddr1;
    logic [4:0]          fwd_raddr2;
    logic                fwd_hit1;
    logic                fwd_hit2;
    logic [DATA_W-1:0]   fwd_data1;
    logic [DATA_W-1:0]   fwd_data2;
`endif

    modport slave (
        input  in_valid, in_gr_we, in_dest, in_result, in_pc, in_badv,
               in_ex, in_ecode, in_badv_we, in_ertn, has_int, retire_ready,
        output in_allowin, rf_we, rf_waddr, rf_wdata, ex_req, ex_ecode,
               ex_pc, ex_badv, ex_badv_we, ertn_req, flush, busy
`ifdef WB_FWD_EN
        , input fwd_raddr1, fwd_raddr2,
        output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
`endif
    );

    modport master (
        output in_valid, in_gr_we, in_dest, in_result, in_pc, in_badv,
               in_ex, in_ecode, in_badv_we, in_ertn, has_int, retire_ready,
        input  in_allowin, rf_we, rf_waddr, rf_wdata, ex_req, ex_ecode,
               ex_pc, ex_badv, ex_badv_we, ertn_req, flush, busy
`ifdef WB_FWD_EN
        , output fwd_raddr1, fwd_raddr2,
        input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
`endif
    );

endinterface

// File: rtl/wb_commit_buffer_fwd_lookup.sv
// Priority scan over commit-buffer entries for one decode read port.
// Module name wb_fwd_lookup; only instantiated when WB_FWD_EN is defined.
module wb_fwd_lookup #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]  cand_i,
    input  logic [4:0]        dest_i   [DEPTH],
    input  logic [DATA_W-1:0] result_i [DEPTH],
    input  logic [PTR_W-1:0]  head_i,
    input  logic [4:0]        raddr_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] data_o
);

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest and let later matches overwrite, so the youngest wins.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = head_i;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_i + PTR_W'(i);
            if (cand_i[idx] && (dest_i[idx] == raddr_i) && (raddr_i != 5'd0)) begin
                hit_o  = 1'b1;
                data_o = result_i[idx];
            end
        end
    end

endmodule

// File: rtl/wb_commit_buffer.sv
// DEPTH-entry in-order writeback/commit buffer with head-of-queue exception/ertn/interrupt handling.
// Define WB_FWD_EN to add combinational result forwarding to the two decode read ports.
module wb_commit_buffer
    import wb_commit_buffer_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 2,
    parameter int ECODE_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    wb_commit_buffer_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DEPTH-1:0]   valid_q, valid_d;

    logic [DEPTH-1:0]   gr_we_q, ex_q, badv_we_q, ertn_q;
    logic [4:0]         dest_q   [DEPTH];
    logic [DATA_W-1:0]  result_q [DEPTH];
    logic [31:0]        pc_q     [DEPTH];
    logic [31:0]        badv_q   [DEPTH];
    logic [ECODE_W-1:0] ecode_q  [DEPTH];

    logic         retire;
    logic         accept;
    retire_kind_e kind;

    // Classify what the head does this cycle; an interrupt outranks everything.
    always_comb begin
        retire = valid_q[head_q] & bus.retire_ready;
        kind   = RET_NONE;
        if (retire) begin
            if (ex_q[head_q] | bus.has_int) begin
                kind = RET_EX;
            end else if (ertn_q[head_q]) begin
                kind = RET_ERTN;
            end else begin
                kind = RET_RF;
            end
        end
    end

    assign bus.rf_we      = (kind == RET_RF) & gr_we_q[head_q] & (dest_q[head_q] != 5'd0);
    assign bus.rf_waddr   = bus.rf_we ? dest_q[head_q] : 5'd0;
    assign bus.rf_wdata   = bus.rf_we ? result_q[head_q] : '0;
    assign bus.ex_req     = (kind == RET_EX);
    assign bus.ex_ecode   = !bus.ex_req ? '0 :
                            bus.has_int ? ECODE_W'(ECODE_INT) : ecode_q[head_q];
    assign bus.ex_pc      = bus.ex_req ? pc_q[head_q] : 32'd0;
    assign bus.ex_badv    = bus.ex_req ? badv_q[head_q] : 32'd0;
    assign bus.ex_badv_we = bus.ex_req & badv_we_q[head_q] & ~bus.has_int;
    assign bus.ertn_req   = (kind == RET_ERTN);
    assign bus.flush      = bus.ex_req | bus.ertn_req;
    assign bus.busy       = (count_q != '0);
    assign bus.in_allowin = (count_q < CNT_W'(DEPTH)) | retire;
    assign accept         = bus.in_valid & bus.in_allowin & ~bus.flush;

    // Retire clears before accept sets, so a full buffer can swap head and tail slot.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            valid_d = '0;
        end else begin
            if (retire) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + PTR_W'(1);
            end
            if (accept) begin
                valid_d[tail_q] = 1'b1;
                tail_d          = tail_q + PTR_W'(1);
            end
            unique case ({accept, retire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            gr_we_q[tail_q]   <= bus.in_gr_we;
            dest_q[tail_q]    <= bus.in_dest;
            result_q[tail_q]  <= bus.in_result;
            pc_q[tail_q]      <= bus.in_pc;
            badv_q[tail_q]    <= bus.in_badv;
            ex_q[tail_q]      <= bus.in_ex;
            ecode_q[tail_q]   <= bus.in_ecode;
            badv_we_q[tail_q] <= bus.in_badv_we;
            ertn_q[tail_q]    <= bus.in_ertn;
        end
    end

`ifdef WB_FWD_EN
    logic [DEPTH-1:0] fwd_cand;
    assign fwd_cand = valid_q & gr_we_q & ~ex_q & ~ertn_q;

    wb_fwd_lookup #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fwd1 (
        .cand_i   (fwd_cand),
        .dest_i   (dest_q),
        .result_i (result_q),
        .head_i   (head_q),
        .raddr_i  (bus.fwd_raddr1),
        .hit_o    (bus.fwd_hit1),
        .data_o   (bus.fwd_data1)
    );

    wb_fwd_lookup #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fwd2 (
        .cand_i   (fwd_cand),
        .dest_i   (dest_q),
        .result_i (result_q),
        .head_i   (head_q),
        .raddr_i  (bus.fwd_raddr2),
        .hit_o    (bus.fwd_hit2),
        .data_o   (bus.fwd_data2)
    );
`endif

endmodule

// File: tb/tb_wb_commit_buffer.sv
// Randomized scoreboard bench for wb_commit_buffer against a queue-based reference model.
// Forwarding checks are compiled in only when WB_FWD_EN is defined.
module tb_wb_commit_buffer;
    import wb_commit_buffer_pkg::*;

    localparam int DATA_W  = 32;
    localparam int DEPTH   = 2;
    localparam int ECODE_W = 6;

    typedef struct {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
        logic [31:0] badv;
        logic        ex;
        logic [5:0]  ecode;
        logic        badv_we;
        logic        ertn;
    } entry_t;

    typedef struct {
        int          kind;   // 1 = RF write, 2 = exception, 3 = ertn
        int          cyc;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [5:0]  ecode;
        logic [31:0] pc;
        logic [31:0] badv;
        logic        badv_we;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cycle = 0;
    int   nCompared = 0;
    int   nMismatched = 0;
    entry_t model[$];
    exp_t   expQ[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    wb_commit_buffer_if #(.DATA_W(DATA_W), .ECODE_W(ECODE_W)) bus ();

    wb_commit_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ECODE_W(ECODE_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        nCompared++;
        if (act !== req) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    function automatic entry_t mkEntry(logic gr_we, logic [4:0] dest, logic [31:0] result,
                                       logic [31:0] pc, logic ex, logic [5:0] ecode,
                                       logic badv_we, logic [31:0] badv, logic ertn);
        entry_t e;
        e.gr_we = gr_we; e.dest = dest; e.result = result; e.pc = pc; e.badv = badv;
        e.ex = ex; e.ecode = ecode; e.badv_we = badv_we; e.ertn = ertn;
        return e;
    endfunction

    // Youngest pending non-faulting write to raddr, as decode should see it.
    function automatic void fwdModel(input logic [4:0] raddr, output logic hit, output logic [31:0] data);
        hit = 1'b0;
        data = 32'd0;
        for (int i = model.size() - 1; i >= 0; i--) begin
            if (!hit && raddr != 5'd0 && model[i].gr_we && model[i].dest == raddr
                && !model[i].ex && !model[i].ertn) begin
                hit = 1'b1;
                data = model[i].result;
            end
        end
    endfunction

    // Called at a negedge: drive one cycle, predict, check handshake, advance model.
    task automatic applyStimulus(input entry_t e, input logic v, input logic hi, input logic rr,
                                 input logic [4:0] ra1, input logic [4:0] ra2);
        logic retire, allow, fl, h1, h2;
        logic [31:0] d1, d2;
        exp_t x;
        bus.in_valid = v;       bus.in_gr_we = e.gr_we;   bus.in_dest = e.dest;
        bus.in_result = e.result; bus.in_pc = e.pc;       bus.in_badv = e.badv;
        bus.in_ex = e.ex;       bus.in_ecode = e.ecode;   bus.in_badv_we = e.badv_we;
        bus.in_ertn = e.ertn;   bus.has_int = hi;         bus.retire_ready = rr;
`ifdef WB_FWD_EN
        bus.fwd_raddr1 = ra1;   bus.fwd_raddr2 = ra2;
`endif
        retire = (model.size() > 0) && rr;
        allow  = (model.size() < DEPTH) || retire;
        fl     = 1'b0;
        fwdModel(ra1, h1, d1);
        fwdModel(ra2, h2, d2);
        x = '{default: '0};
        x.cyc = cycle;
        if (retire) begin
            if (model[0].ex || hi) begin
                x.kind = 2; x.ecode = hi ? 6'h00 : model[0].ecode; x.pc = model[0].pc;
                x.badv = model[0].badv; x.badv_we = model[0].badv_we && !hi;
                expQ.push_back(x);
                fl = 1'b1;
            end else if (model[0].ertn) begin
                x.kind = 3;
                expQ.push_back(x);
                fl = 1'b1;
            end else if (model[0].gr_we && model[0].dest != 5'd0) begin
                x.kind = 1; x.waddr = model[0].dest; x.wdata = model[0].result;
                expQ.push_back(x);
            end
        end
        #1;
        checkOutput("in_allowin", bus.in_allowin, allow);
        checkOutput("busy", bus.busy, model.size() != 0);
`ifdef WB_FWD_EN
        checkOutput("fwd_hit1", bus.fwd_hit1, h1);
        checkOutput("fwd_hit2", bus.fwd_hit2, h2);
        if (h1) checkOutput("fwd_data1", bus.fwd_data1, d1);
        if (h2) checkOutput("fwd_data2", bus.fwd_data2, d2);
`else
        if (ra1 != ra2) checkOutput("ra_unused", 64'(ra1 == ra2), 64'(ra1 == ra2 || ra1 != ra2) - 64'd1);
`endif
        if (fl) begin
            model.delete();
        end else begin
            if (retire) void'(model.pop_front());
            if (v && allow) model.push_back(e);
        end
        @(negedge clk);
    endtask

    // Monitor: pops an expectation whenever the DUT presents a retirement.
    initial begin
        exp_t x;
        logic present;
        forever begin
            @(negedge clk);
            #1;
            if (reset) continue;
            if (expQ.size() > 0 && expQ[0].cyc < cycle) begin
                checkOutput("missed_retire", 64'(expQ[0].cyc), 64'(cycle));
                void'(expQ.pop_front());
            end
            present = bus.rf_we | bus.ex_req | bus.ertn_req;
            if (present) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_retire", present, 1'b0);
                end else begin
                    x = expQ.pop_front();
                    checkOutput("retire_cycle", 64'(cycle), 64'(x.cyc));
                    checkOutput("retire_flags", {bus.rf_we, bus.ex_req, bus.ertn_req, bus.flush},
                                {x.kind == 1, x.kind == 2, x.kind == 3, x.kind != 1});
                    if (x.kind == 1) begin
                        checkOutput("rf_waddr", bus.rf_waddr, x.waddr);
                        checkOutput("rf_wdata", bus.rf_wdata, x.wdata);
                    end else if (x.kind == 2) begin
                        checkOutput("ex_ecode", bus.ex_ecode, x.ecode);
                        checkOutput("ex_pc", bus.ex_pc, x.pc);
                        checkOutput("ex_badv_we", bus.ex_badv_we, x.badv_we);
                        if (x.badv_we) checkOutput("ex_badv", bus.ex_badv, x.badv);
                    end
                end
            end
        end
    end

    initial begin
        entry_t idle, e;
        idle = mkEntry(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        bus.in_valid = 0; bus.in_gr_we = 0; bus.in_dest = 0; bus.in_result = 0; bus.in_pc = 0;
        bus.in_badv = 0; bus.in_ex = 0; bus.in_ecode = 0; bus.in_badv_we = 0; bus.in_ertn = 0;
        bus.has_int = 0; bus.retire_ready = 0;
`ifdef WB_FWD_EN
        bus.fwd_raddr1 = 0; bus.fwd_raddr2 = 0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("reset_allowin", bus.in_allowin, 1'b1);
        checkOutput("reset_busy", bus.busy, 1'b0);
        checkOutput("reset_retire_outs", {bus.rf_we, bus.ex_req, bus.ertn_req, bus.flush}, 4'b0000);
`ifdef WB_FWD_EN
        checkOutput("reset_fwd_hits", {bus.fwd_hit1, bus.fwd_hit2}, 2'b00);
`endif
        @(negedge clk);

        // Single write, retired the cycle after accept.
        applyStimulus(mkEntry(1, 5, 32'h1234, 32'h1C000000, 0, 0, 0, 0, 0), 1, 0, 1, 0, 0);
        applyStimulus(idle, 0, 0, 1, 5, 0);
        applyStimulus(idle, 0, 0, 1, 0, 0);

        // Fill with retire_ready low, third offer refused, then drain in order.
        applyStimulus(mkEntry(1, 1, 32'hA, 32'h100, 0, 0, 0, 0, 0), 1, 0, 0, 1, 0);
        applyStimulus(mkEntry(1, 2, 32'hB, 32'h104, 0, 0, 0, 0, 0), 1, 0, 0, 1, 2);
        e = mkEntry(1, 3, 32'hC, 32'h108, 0, 0, 0, 0, 0);
        applyStimulus(e, 1, 0, 0, 2, 3);
        applyStimulus(e, 1, 0, 1, 3, 1);
        repeat (3) applyStimulus(idle, 0, 0, 1, 3, 0);

        // SYS at head with a younger entry queued; concurrent offer dropped.
        applyStimulus(mkEntry(1, 6, 32'h66, 32'h1C000010, 1, ECODE_SYS, 0, 0, 0), 1, 0, 0, 6, 0);
        applyStimulus(mkEntry(1, 4, 32'h44, 32'h1C000014, 0, 0, 0, 0, 0), 1, 0, 0, 6, 4);
        applyStimulus(mkEntry(1, 9, 32'h99, 32'h1C000018, 0, 0, 0, 0, 0), 1, 0, 1, 4, 9);
        applyStimulus(idle, 0, 0, 1, 9, 0);

        // Interrupt overrides an ALE head; interrupt with empty buffer does nothing.
        applyStimulus(mkEntry(1, 8, 32'h88, 32'h200, 1, ECODE_ALE, 1, 32'hBADD, 0), 1, 0, 0, 0, 0);
        applyStimulus(idle, 0, 1, 1, 0, 0);
        applyStimulus(idle, 0, 1, 1, 0, 0);

        // ertn at head.
        applyStimulus(mkEntry(0, 0, 0, 32'h300, 0, 0, 0, 0, 1), 1, 0, 1, 0, 0);
        applyStimulus(idle, 0, 0, 1, 0, 0);

        // Two writes to r7: youngest forwards, r0 never hits.
        applyStimulus(mkEntry(1, 7, 32'hAA, 32'h400, 0, 0, 0, 0, 0), 1, 0, 0, 7, 0);
        applyStimulus(mkEntry(1, 7, 32'hBB, 32'h404, 0, 0, 0, 0, 0), 1, 0, 0, 7, 0);
        applyStimulus(idle, 0, 0, 0, 7, 0);
        applyStimulus(idle, 0, 0, 1, 7, 0);
        applyStimulus(idle, 0, 0, 1, 7, 7);

        for (int n = 0; n < 2000; n++) begin
            e = mkEntry($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom, $urandom,
                        $urandom_range(0, 15) == 0, 6'($urandom_range(8, 13)),
                        1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 19) == 0);
            applyStimulus(e, $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
                          $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        repeat (4) applyStimulus(idle, 0, 0, 1, 0, 0);
        checkOutput("pending_expectations", 64'(expQ.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
